// File: rtl/iiitb_tlc_timed.sv
// Timed highway/farm-road traffic light controller with all-red clearance,
// latched farm request, farm max-green cutoff and night flashing mode.
module iiitb_tlc_timed #(
    parameter int TMR_W      = 16,
    parameter int HG_MIN     = 8,
    parameter int Y_TIME     = 3,
    parameter int AR_TIME    = 2,
    parameter int FG_MIN     = 4,
    parameter int FG_MAX     = 10,
    parameter int FLASH_HALF = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       C,
    input  logic       flash_en,
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
    output logic       farm_served
);

    typedef enum logic [2:0] {
        HGRE_FRED,
        HYEL_FRED,
        AR1,
        HRED_FGRE,
        HRED_FYEL,
        AR2,
        FLASH
    } state_t;

    localparam logic [TMR_W-1:0] HG_LAST  = TMR_W'(HG_MIN - 1);
    localparam logic [TMR_W-1:0] Y_LAST   = TMR_W'(Y_TIME - 1);
    localparam logic [TMR_W-1:0] AR_LAST  = TMR_W'(AR_TIME - 1);
    localparam logic [TMR_W-1:0] FGN_LAST = TMR_W'(FG_MIN - 1);
    localparam logic [TMR_W-1:0] FGX_LAST = TMR_W'(FG_MAX - 1);
    localparam logic [TMR_W-1:0] FH_LAST  = TMR_W'(FLASH_HALF - 1);
    localparam logic [TMR_W-1:0] TMR_SAT  = '1;

    state_t           state, nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             farm_req, farm_req_nxt;
    logic             blink, blink_nxt;
    logic             c_meta, c_s;
    logic             changing;

    // {highway, farm} lamp pattern for a state; blink only matters in FLASH
    function automatic logic [5:0] lamps(input state_t s, input logic b);
        logic [5:0] l;
        case (s)
            HGRE_FRED: l = 6'b001_100;
            HYEL_FRED: l = 6'b010_100;
            HRED_FGRE: l = 6'b100_001;
            HRED_FYEL: l = 6'b100_010;
            FLASH:     l = b ? 6'b010_100 : 6'b000_000;
            default:   l = 6'b100_100;
        endcase
        return l;
    endfunction

    always_comb begin
        nxt = state;
        if (flash_en) begin
            nxt = FLASH;
        end else begin
            case (state)
                HGRE_FRED: if (tmr >= HG_LAST && farm_req) nxt = HYEL_FRED;
                HYEL_FRED: if (tmr == Y_LAST) nxt = AR1;
                AR1:       if (tmr == AR_LAST) nxt = HRED_FGRE;
                HRED_FGRE: if ((tmr >= FGN_LAST && !c_s) || tmr == FGX_LAST) nxt = HRED_FYEL;
                HRED_FYEL: if (tmr == Y_LAST) nxt = AR2;
                AR2:       if (tmr == AR_LAST) nxt = HGRE_FRED;
                default:   nxt = AR2;
            endcase
        end
    end

    assign changing = (nxt != state);

    always_comb begin
        // In FLASH the timer doubles as the half-period counter
        if (changing || (nxt == FLASH && tmr == FH_LAST))
            tmr_nxt = '0;
        else if (tmr != TMR_SAT)
            tmr_nxt = tmr + 1'b1;
        else
            tmr_nxt = tmr;

        if (nxt != FLASH)
            blink_nxt = 1'b0;
        else if (changing)
            blink_nxt = 1'b1;
        else if (tmr == FH_LAST)
            blink_nxt = ~blink;
        else
            blink_nxt = blink;

        if (changing && (nxt == HRED_FGRE || nxt == FLASH))
            farm_req_nxt = 1'b0;
        else if (c_s && state != HRED_FGRE && state != FLASH)
            farm_req_nxt = 1'b1;
        else
            farm_req_nxt = farm_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= AR2;
            tmr           <= '0;
            farm_req      <= 1'b0;
            blink         <= 1'b0;
            c_meta        <= 1'b0;
            c_s           <= 1'b0;
            light_highway <= 3'b100;
            light_farm    <= 3'b100;
            farm_served   <= 1'b0;
        end else begin
            c_meta   <= C;
            c_s      <= c_meta;
            state    <= nxt;
            tmr      <= tmr_nxt;
            farm_req <= farm_req_nxt;
            blink    <= blink_nxt;
            {light_highway, light_farm} <= lamps(nxt, blink_nxt);
            farm_served <= changing && (nxt == HRED_FGRE);
        end
    end

endmodule
